div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameters: none; datapath width is fixed at 32 bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 DivCtrl  input  1  start request, sampled only in IDLE.
REQ-005 a  input  32  dividend, two's complement.
REQ-006 b  input  32  divisor, two's complement.
REQ-007 hi  output  32  remainder, registered; feeds HI and the mult/div result mux.
REQ-008 lo  output  32  quotient, registered; feeds LO and the mult/div result mux.
REQ-009 done  output  1  one-cycle pulse: hi/lo hold a new valid result.
REQ-010 divZero  output  1  one-cycle pulse: divide-by-zero exception.
REQ-011 busy  output  1  high while in RUN or FIN.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and FIN, and SHALL be encoded in a single state register.
REQ-013 In IDLE with DivCtrl=1 and b!=0, the block SHALL latch sign(a), sign(b), |a| and |b| at that edge, clear the partial remainder and the 6-bit counter, and go to RUN.
REQ-014 In IDLE with DivCtrl=1 and b==0, the block SHALL pulse divZero=1 for exactly the next cycle, keep hi/lo unchanged, keep done=0, and stay in IDLE.
REQ-015 In RUN, each edge SHALL perform one restoring step: shift {rem,quo} left 1 bit; if the trial rem-|b| is >=0, keep it and set quo[0]=1, else restore rem and set quo[0]=0.
REQ-016 After the 32nd RUN edge, the block SHALL go to FIN; the counter SHALL terminate at exactly 32 steps.
REQ-017 In FIN, lo SHALL get the quotient negated iff sign(a)!=sign(b), hi SHALL get the remainder negated iff sign(a)=1, done SHALL be 1 for that cycle, and the block SHALL return to IDLE.
REQ-018 The quotient SHALL truncate toward zero and the remainder SHALL take the sign of the dividend, following MIPS DIV semantics.
REQ-019 For 0x80000000 / 0xFFFFFFFF, the block SHALL produce lo=0x80000000 and hi=0 (natural 32-bit wrap) and SHALL raise no flag.
REQ-020 The absolute value of 0x80000000 SHALL be handled as unsigned 0x80000000, which requires no 33rd bit.
REQ-021 Latency: with DivCtrl sampled at edge E0, hi/lo SHALL update at E33 and done SHALL be high from E33 to E34.
REQ-022 DivCtrl SHALL be ignored while busy=1.
REQ-023 Changes on a/b after E0 SHALL NOT affect the result.
REQ-024 DivCtrl=1 in the cycle where done=1 SHALL be accepted at the next edge, since the block is back in IDLE; back-to-back operations therefore have a spacing of 34 cycles.
REQ-025 hi and lo SHALL hold their last value indefinitely until the next FIN or reset.
REQ-026 done and divZero SHALL never be high in the same cycle.

Reset
REQ-027 On reset=1 at an edge, state SHALL be IDLE, and hi, lo, done, divZero, busy and all internal registers SHALL be 0.
REQ-028 Reset SHALL take precedence over DivCtrl and over any RUN/FIN activity.
REQ-029 A reset during an operation SHALL abort it with no done and no partial result on hi/lo.
REQ-030 After reset deasserts, the next DivCtrl SHALL start a fresh operation normally.

Verification
REQ-031 a=100, b=7, DivCtrl pulsed at E0 -> lo=14, hi=2, done=1 exactly at E33, busy=1 from E1 through E33.
REQ-032 a=-100, b=7 -> lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2); a=100, b=-7 -> lo=-14, hi=2; a=-100, b=-7 -> lo=14, hi=-2.
REQ-033 a=5, b=0, DivCtrl pulsed -> divZero=1 for one cycle after E0, done never asserts, hi/lo retain the prior result, busy=0.
REQ-034 a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, divZero=0; a=0, b=3 -> lo=0, hi=0.
REQ-035 Start 100/7, pulse DivCtrl again at E10 with a=9, b=3 -> the second request is ignored and the result is 14/2; then reset at E5 of a new 50/5 run -> hi=lo=0, busy=0, no done; restart 50/5 -> lo=10, hi=0.
REQ-036 The bench SHALL compare every operation against a reference model and check done/divZero pulse widths over at least 1000 random signed operand pairs, including b=±1, a=b and |a|<|b|.

Source files
------------

// File: rtl/div_seq_if.sv
// ---------------------------------------------------------------------------
// div_seq_if
// Bundles the request/result signals of the sequential signed divider.
//   DivCtrl : start request (requester -> divider)
//   a, b    : 32-bit two's complement dividend / divisor
//   hi, lo  : registered remainder / quotient
//   done    : one-cycle pulse, hi/lo carry a new result
//   divZero : one-cycle pulse, divide-by-zero exception
//   busy    : divider is working (RUN or FIN)
// master = requester side, slave = divider side.
// ---------------------------------------------------------------------------
interface div_seq_if;
    logic        DivCtrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        done;
    logic        divZero;
    logic        busy;

    modport master (
        output DivCtrl, a, b,
        input  hi, lo, done, divZero, busy
    );

    modport slave (
        input  DivCtrl, a, b,
        output hi, lo, done, divZero, busy
    );
endinterface

// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq
// 32-bit signed restoring divider with MIPS DIV semantics: the quotient
// truncates toward zero and the remainder takes the sign of the dividend.
// A request takes 34 cycles from acceptance to the next acceptable request:
// one cycle to latch operands, 32 restoring steps, one sign-fixup cycle.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high reset
//   bus    : div_seq_if.slave (DivCtrl, a, b in; hi, lo, done, divZero,
//            busy out; all outputs are registered)
// ---------------------------------------------------------------------------
module div_seq (
    input  logic       clk,
    input  logic       reset,
    div_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Magnitude of a two's complement word. 0x80000000 maps onto itself,
    // which read as unsigned is exactly 2^31, so no 33rd bit is needed.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        logic [31:0] r;
        if (v[31]) begin
            r = 32'd0 - v;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Conditional two's complement negate with natural 32-bit wrap.
    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
        logic [31:0] r;
        if (en) begin
            r = 32'd0 - v;
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t      state_r;
    logic [5:0]  cnt_r;
    logic [31:0] rem_r;
    logic [31:0] quo_r;
    logic [31:0] babs_r;
    logic        sa_r;
    logic        sb_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        done_r;
    logic        dz_r;
    logic        busy_r;

    logic [32:0] rem_sh_s;
    logic [32:0] diff_s;
    logic        qbit_s;
    logic [31:0] rem_next_s;
    logic [31:0] quo_next_s;

    // One restoring step: shift {rem,quo} left, trial-subtract |b|, keep or restore.
    // The remainder is always below |b| <= 2^31, so the shifted value fits
    // in 33 bits and diff_s[32] is a clean borrow flag.
    always_comb begin
        rem_sh_s   = {rem_r, quo_r[31]};
        diff_s     = rem_sh_s - {1'b0, babs_r};
        qbit_s     = 1'b0;
        rem_next_s = rem_sh_s[31:0];
        if (diff_s[32] == 1'b0) begin
            qbit_s     = 1'b1;
            rem_next_s = diff_s[31:0];
        end else begin
            qbit_s     = 1'b0;
            rem_next_s = rem_sh_s[31:0];
        end
        quo_next_s = {quo_r[30:0], qbit_s};
    end

    // Control FSM and datapath registers; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 6'd0;
            rem_r   <= 32'd0;
            quo_r   <= 32'd0;
            babs_r  <= 32'd0;
            sa_r    <= 1'b0;
            sb_r    <= 1'b0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            done_r  <= 1'b0;
            dz_r    <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            // Pulses last one cycle unless a state below re-asserts them.
            done_r <= 1'b0;
            dz_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.DivCtrl) begin
                        if (bus.b != 32'd0) begin
                            // Dividend magnitude seeds the quotient register;
                            // it is shifted out into rem one bit per step.
                            sa_r    <= bus.a[31];
                            sb_r    <= bus.b[31];
                            quo_r   <= abs32(bus.a);
                            babs_r  <= abs32(bus.b);
                            rem_r   <= 32'd0;
                            cnt_r   <= 6'd0;
                            busy_r  <= 1'b1;
                            state_r <= RUN;
                        end else begin
                            // Divide by zero: flag only, results untouched.
                            dz_r    <= 1'b1;
                            state_r <= IDLE;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    rem_r <= rem_next_s;
                    quo_r <= quo_next_s;
                    cnt_r <= cnt_r + 6'd1;
                    if (cnt_r == 6'd31) begin
                        state_r <= FIN;
                    end else begin
                        state_r <= RUN;
                    end
                end
                FIN: begin
                    // Quotient sign is the XOR of operand signs; the remainder
                    // follows the dividend. -2^31 / -1 wraps back to -2^31.
                    lo_r    <= neg_if(quo_r, sa_r ^ sb_r);
                    hi_r    <= neg_if(rem_r, sa_r);
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.hi      = hi_r;
    assign bus.lo      = lo_r;
    assign bus.done    = done_r;
    assign bus.divZero = dz_r;
    assign bus.busy    = busy_r;

endmodule

// File: tb/tb_div_seq.sv
// ---------------------------------------------------------------------------
// tb_div_seq
// Directed and random self-checking bench for div_seq. Directed vectors carry
// hand-computed results; random operations are compared against an
// unsigned-magnitude reference model.
// ---------------------------------------------------------------------------
module tb_div_seq;

    logic clk;
    logic reset;

    div_seq_if bus ();

    div_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Observations collected by run_op.
    int          done_at;
    int          done_cnt;
    int          dz_at;
    int          dz_cnt;
    int          busy_cnt;
    int          both_cnt;
    logic [31:0] obs_hi;
    logic [31:0] obs_lo;

    // Directed vectors: dividend, divisor, quotient, remainder.
    logic [31:0] dir_a [0:8] = '{32'd100, 32'hFFFFFF9C, 32'd100, 32'hFFFFFF9C,
                                 32'h80000000, 32'd0, 32'h7FFFFFFF, 32'h80000000, 32'h80000000};
    logic [31:0] dir_b [0:8] = '{32'd7, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                 32'hFFFFFFFF, 32'd3, 32'h80000000, 32'h80000000, 32'd2};
    logic [31:0] dir_q [0:8] = '{32'd14, 32'hFFFFFFF2, 32'hFFFFFFF2, 32'd14,
                                 32'h80000000, 32'd0, 32'd0, 32'd1, 32'hC0000000};
    logic [31:0] dir_r [0:8] = '{32'd2, 32'hFFFFFFFE, 32'd2, 32'hFFFFFFFE,
                                 32'd0, 32'd0, 32'h7FFFFFFF, 32'd0, 32'd0};

    // 10-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Single comparison point: counts, and reports any mismatch.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: divide magnitudes unsigned, then apply MIPS sign rules.
    function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] q, output logic [31:0] r);
        logic [31:0] ux;
        logic [31:0] uy;
        logic [31:0] uq;
        logic [31:0] ur;
        ux = x[31] ? (32'd0 - x) : x;
        uy = y[31] ? (32'd0 - y) : y;
        uq = ux / uy;
        ur = ux % uy;
        q  = (x[31] ^ y[31]) ? (32'd0 - uq) : uq;
        r  = x[31] ? (32'd0 - ur) : ur;
    endfunction

    // Issue one request and watch 35 cycles (k = 0 is the sample after E0).
    // inj_k: cycle after which a second DivCtrl (9/3) is driven, -1 for none.
    // rst_k: cycle after which reset is driven for one edge, -1 for none.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tbv,
                          input int inj_k, input int rst_k, input bit scramble);
        bus.a       = ta;
        bus.b       = tbv;
        bus.DivCtrl = 1'b1;
        done_at  = -1;
        done_cnt = 0;
        dz_at    = -1;
        dz_cnt   = 0;
        busy_cnt = 0;
        both_cnt = 0;
        for (int k = 0; k <= 34; k++) begin
            @(posedge clk);
            #1;
            bus.DivCtrl = 1'b0;
            reset       = 1'b0;
            if (scramble) begin
                bus.a = $urandom;
                bus.b = $urandom;
            end
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (bus.divZero) begin
                dz_cnt++;
                if (dz_at < 0) dz_at = k;
            end
            if (bus.busy) busy_cnt++;
            if (bus.done && bus.divZero) both_cnt++;
            if (k == inj_k) begin
                bus.a       = 32'd9;
                bus.b       = 32'd3;
                bus.DivCtrl = 1'b1;
            end
            if (k == rst_k) reset = 1'b1;
        end
        obs_hi = bus.hi;
        obs_lo = bus.lo;
    endtask

    // Checks for a normal completed operation.
    task automatic check_op(input string pfx, input logic [31:0] exp_q, input logic [31:0] exp_r);
        check({pfx, "_lo"},       obs_lo,            exp_q);
        check({pfx, "_hi"},       obs_hi,            exp_r);
        check({pfx, "_done_at"},  32'(done_at),      32'd33);
        check({pfx, "_done_cnt"}, 32'(done_cnt),     32'd1);
        check({pfx, "_dz_cnt"},   32'(dz_cnt),       32'd0);
        check({pfx, "_busy_cnt"}, 32'(busy_cnt),     32'd33);
        check({pfx, "_overlap"},  32'(both_cnt),     32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] rq;
        logic [31:0] rr;

        reset       = 1'b1;
        bus.DivCtrl = 1'b0;
        bus.a       = 32'd0;
        bus.b       = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hi",      bus.hi,              32'd0);
        check("rst_lo",      bus.lo,              32'd0);
        check("rst_done",    32'(bus.done),       32'd0);
        check("rst_divzero", 32'(bus.divZero),    32'd0);
        check("rst_busy",    32'(bus.busy),       32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed vectors, operands scrambled after acceptance.
        for (int i = 0; i < 9; i++) begin
            run_op(dir_a[i], dir_b[i], -1, -1, 1'b1);
            check_op("dir", dir_q[i], dir_r[i]);
        end

        // Divide by zero: one-cycle flag right after E0, results retained.
        run_op(32'd5, 32'd0, -1, -1, 1'b0);
        check("dz_at",       32'(dz_at),    32'd0);
        check("dz_cnt",      32'(dz_cnt),   32'd1);
        check("dz_done_cnt", 32'(done_cnt), 32'd0);
        check("dz_busy_cnt", 32'(busy_cnt), 32'd0);
        check("dz_lo_kept",  obs_lo,        32'hC0000000);
        check("dz_hi_kept",  obs_hi,        32'd0);

        // Second request at E10 while busy is ignored.
        run_op(32'd100, 32'd7, 9, -1, 1'b0);
        check_op("ignore", 32'd14, 32'd2);

        // Reset at E5 aborts the operation and clears results.
        run_op(32'd50, 32'd5, -1, 4, 1'b0);
        check("abort_done_cnt", 32'(done_cnt), 32'd0);
        check("abort_busy_cnt", 32'(busy_cnt), 32'd5);
        check("abort_lo",       obs_lo,        32'd0);
        check("abort_hi",       obs_hi,        32'd0);
        check("abort_busy",     32'(bus.busy), 32'd0);

        // Fresh operation after reset.
        run_op(32'd50, 32'd5, -1, -1, 1'b0);
        check_op("restart", 32'd10, 32'd0);

        // Back-to-back: request in the done cycle is accepted at the next edge.
        bus.a       = 32'd20;
        bus.b       = 32'd4;
        bus.DivCtrl = 1'b1;
        for (int k = 0; k <= 33; k++) begin
            @(posedge clk);
            #1;
            bus.DivCtrl = 1'b0;
        end
        check("b2b_first_done", 32'(bus.done), 32'd1);
        check("b2b_first_lo",   bus.lo,        32'd5);
        bus.a       = 32'd21;
        bus.b       = 32'd4;
        bus.DivCtrl = 1'b1;
        @(posedge clk);
        #1;
        bus.DivCtrl = 1'b0;
        check("b2b_accept_busy", 32'(bus.busy), 32'd1);
        for (int k = 1; k <= 33; k++) begin
            @(posedge clk);
            #1;
        end
        check("b2b_second_done", 32'(bus.done), 32'd1);
        check("b2b_second_lo",   bus.lo,        32'd5);
        check("b2b_second_hi",   bus.hi,        32'd1);
        @(posedge clk);
        #1;

        // Random signed operands with forced corner mixes.
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            case (i % 8)
                0: rb = 32'd1;
                1: rb = 32'hFFFFFFFF;
                2: begin
                    if (rb == 32'd0) rb = 32'd3;
                    ra = rb;
                end
                3: begin
                    rb = {1'b0, 1'b1, rb[29:0]};
                    if (rb[0]) rb = 32'd0 - rb;
                    ra = 32'($urandom_range(0, 1000));
                    if (ra[0]) ra = 32'd0 - ra;
                end
                default: begin
                    if (rb == 32'd0) rb = 32'd1;
                end
            endcase
            ref_div(ra, rb, rq, rr);
            run_op(ra, rb, -1, -1, 1'b1);
            check_op("rnd", rq, rr);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
